brq_mem_arbiter: RTL and testbench

BRQ_MEM_ARBITER -- requirements
Module: brq_mem_arbiter

---
 rtl/brq_pkg.sv | 24 ++
 rtl/brq_arb_pick.sv | 36 +++
 rtl/brq_mem_arbiter.sv | 161 ++++++++++++++++
 tb/tb_brq_mem_arbiter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/brq_pkg.sv
// Shared types for the instruction/data memory arbiter.
//
// Contents:
//   rsp_state_e  - response-owner state: which port receives the
//                  memory result in the cycle after a grant.
//   gnt_owner_e  - which request port (if any) owns the memory this cycle.
//   FetchByteEn  - byte enable driven for every fetch access (full word).
package brq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IF_RSP = 2'd1,
    LS_RSP = 2'd2
  } rsp_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_LS   = 2'd2
  } gnt_owner_e;

  localparam logic [3:0] FetchByteEn = 4'b1111;

endpackage

// File: rtl/brq_arb_pick.sv
// Combinational grant selection between the fetch and load/store ports.
//
// Ports:
//   enable      - in,  1: when low no port is granted (held low in reset)
//   if_valid    - in,  1: fetch request pending
//   ls_valid    - in,  1: load/store request pending
//   fetch_first - in,  1: on a conflict the fetch port wins when high,
//                         otherwise load/store wins
//   owner       - out, gnt_owner_e: granted port for this cycle
//
// The policy that produces fetch_first (starvation limit or round-robin
// pointer) lives in the parent; this block only resolves the choice.
module brq_arb_pick
  import brq_pkg::*;
(
  input  logic       enable,
  input  logic       if_valid,
  input  logic       ls_valid,
  input  logic       fetch_first,
  output gnt_owner_e owner
);

  always_comb begin
    owner = OWN_NONE;
    if (enable) begin
      if (if_valid && ls_valid) begin
        owner = fetch_first ? OWN_IF : OWN_LS;
      end else if (if_valid) begin
        owner = OWN_IF;
      end else if (ls_valid) begin
        owner = OWN_LS;
      end
    end
  end

endmodule

// File: rtl/brq_mem_arbiter.sv
// Arbiter sharing one single-port, 1-cycle-latency memory between an
// instruction-fetch port and a load/store port. One grant per cycle; the
// granted request drives the memory combinationally and its response is
// returned on the owner's rsp port exactly one cycle later.
//
// Configuration macro: BRQ_ARB_RR_EN
//   undefined - fixed priority, load/store wins conflicts unless fetch has
//               waited StarveLimit consecutive cycles
//   defined   - round-robin, the port not granted last wins conflicts
//
// Ports:
//   brq_clk, brq_rst (async, active-low)
//   if_req_valid/if_req_addr/if_req_ready        fetch request
//   if_rsp_valid/if_rsp_data                     fetch response
//   ls_req_valid/we/addr/wdata/byte_en/ready     load/store request
//   ls_rsp_valid/ls_rsp_data                     load/store response
//   mem_re/we/addr/wdata/byte_en, mem_rdata      memory side
module brq_mem_arbiter
  import brq_pkg::*;
#(
  parameter int DataWidth   = 32,
  parameter int AddrWidth   = 15,
  parameter int StarveLimit = 4
) (
  input  logic                 brq_clk,
  input  logic                 brq_rst,

  input  logic                 if_req_valid,
  input  logic [AddrWidth-1:0] if_req_addr,
  output logic                 if_req_ready,
  output logic                 if_rsp_valid,
  output logic [DataWidth-1:0] if_rsp_data,

  input  logic                 ls_req_valid,
  input  logic                 ls_req_we,
  input  logic [AddrWidth-1:0] ls_req_addr,
  input  logic [DataWidth-1:0] ls_req_wdata,
  input  logic [3:0]           ls_req_byte_en,
  output logic                 ls_req_ready,
  output logic                 ls_rsp_valid,
  output logic [DataWidth-1:0] ls_rsp_data,

  output logic                 mem_re,
  output logic                 mem_we,
  output logic [AddrWidth-1:0] mem_addr,
  output logic [DataWidth-1:0] mem_wdata,
  output logic [3:0]           mem_byte_en,
  input  logic [DataWidth-1:0] mem_rdata
);

  gnt_owner_e owner;
  rsp_state_e state, state_next;
  logic       fetch_first;
  logic       ls_wr_q;

  // Grants are gated by reset so ready and mem_* drop asynchronously.
  brq_arb_pick u_pick (
    .enable      (brq_rst),
    .if_valid    (if_req_valid),
    .ls_valid    (ls_req_valid),
    .fetch_first (fetch_first),
    .owner       (owner)
  );

`ifdef BRQ_ARB_RR_EN
  // last_ls == 0 means fetch counts as last granted, so after reset the
  // load/store port wins the first conflict.
  logic last_ls;

  always_ff @(posedge brq_clk or negedge brq_rst) begin
    if (!brq_rst) begin
      last_ls <= 1'b0;
    end else if (owner == OWN_IF) begin
      last_ls <= 1'b0;
    end else if (owner == OWN_LS) begin
      last_ls <= 1'b1;
    end
  end

  assign fetch_first = last_ls;
`else
  localparam int CntWidth = (StarveLimit < 1) ? 1 : $clog2(StarveLimit + 1);
  localparam logic [CntWidth-1:0] CntMax = CntWidth'(StarveLimit);

  logic [CntWidth-1:0] starve_cnt;

  // Counts consecutive cycles fetch waited; saturates rather than wraps so
  // a long wait keeps fetch at forced priority until it is served.
  always_ff @(posedge brq_clk or negedge brq_rst) begin
    if (!brq_rst) begin
      starve_cnt <= '0;
    end else if (!if_req_valid || owner == OWN_IF) begin
      starve_cnt <= '0;
    end else if (starve_cnt != CntMax) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  assign fetch_first = (starve_cnt == CntMax);
`endif

  // ls_wr_q remembers that the pending load/store response is a write,
  // whose response carries zero data instead of mem_rdata.
  always_ff @(posedge brq_clk or negedge brq_rst) begin
    if (!brq_rst) begin
      state   <= IDLE;
      ls_wr_q <= 1'b0;
    end else begin
      state   <= state_next;
      ls_wr_q <= (owner == OWN_LS) && ls_req_we;
    end
  end

  always_comb begin
    state_next   = IDLE;
    if_req_ready = 1'b0;
    ls_req_ready = 1'b0;
    mem_re       = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    mem_byte_en  = 4'b0000;
    if_rsp_valid = 1'b0;
    if_rsp_data  = '0;
    ls_rsp_valid = 1'b0;
    ls_rsp_data  = '0;

    case (owner)
      OWN_IF: begin
        if_req_ready = 1'b1;
        mem_re       = 1'b1;
        mem_addr     = if_req_addr;
        mem_byte_en  = FetchByteEn;
        state_next   = IF_RSP;
      end
      OWN_LS: begin
        ls_req_ready = 1'b1;
        mem_re       = !ls_req_we;
        mem_we       = ls_req_we;
        mem_addr     = ls_req_addr;
        mem_wdata    = ls_req_wdata;
        mem_byte_en  = ls_req_byte_en;
        state_next   = LS_RSP;
      end
      default: ;
    endcase

    case (state)
      IF_RSP: begin
        if_rsp_valid = 1'b1;
        if_rsp_data  = mem_rdata;
      end
      LS_RSP: begin
        ls_rsp_valid = 1'b1;
        ls_rsp_data  = ls_wr_q ? '0 : mem_rdata;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_brq_mem_arbiter.sv
// Self-checking bench for brq_mem_arbiter: directed cases plus a random
// phase, checked by a request-level reference model feeding a response
// scoreboard that a separate monitor drains.
module tb_brq_mem_arbiter;

  localparam int DW       = 32;
  localparam int AW       = 15;
  localparam int SL       = 4;
  localparam int MemWords = 1 << AW;

  logic          brq_clk = 1'b0;
  logic          brq_rst = 1'b0;
  logic          if_req_valid = 1'b0;
  logic [AW-1:0] if_req_addr = '0;
  logic          if_req_ready;
  logic          if_rsp_valid;
  logic [DW-1:0] if_rsp_data;
  logic          ls_req_valid = 1'b0;
  logic          ls_req_we = 1'b0;
  logic [AW-1:0] ls_req_addr = '0;
  logic [DW-1:0] ls_req_wdata = '0;
  logic [3:0]    ls_req_byte_en = '0;
  logic          ls_req_ready;
  logic          ls_rsp_valid;
  logic [DW-1:0] ls_rsp_data;
  logic          mem_re;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [3:0]    mem_byte_en;
  logic [DW-1:0] mem_rdata = '0;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  typedef struct {
    int            stamp;
    bit            is_if;
    logic [DW-1:0] data;
  } exp_t;

  exp_t sb_q[$];

  logic [DW-1:0] phys_mem [0:MemWords-1];
  logic [DW-1:0] ref_mem  [0:MemWords-1];

  always #5 brq_clk = ~brq_clk;

  brq_mem_arbiter #(.DataWidth(DW), .AddrWidth(AW), .StarveLimit(SL)) dut (
    .brq_clk        (brq_clk),
    .brq_rst        (brq_rst),
    .if_req_valid   (if_req_valid),
    .if_req_addr    (if_req_addr),
    .if_req_ready   (if_req_ready),
    .if_rsp_valid   (if_rsp_valid),
    .if_rsp_data    (if_rsp_data),
    .ls_req_valid   (ls_req_valid),
    .ls_req_we      (ls_req_we),
    .ls_req_addr    (ls_req_addr),
    .ls_req_wdata   (ls_req_wdata),
    .ls_req_byte_en (ls_req_byte_en),
    .ls_req_ready   (ls_req_ready),
    .ls_rsp_valid   (ls_rsp_valid),
    .ls_rsp_data    (ls_rsp_data),
    .mem_re         (mem_re),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_byte_en    (mem_byte_en),
    .mem_rdata      (mem_rdata)
  );

  // Physical memory driven only by the DUT's mem_* outputs; idle cycles
  // return noise so a response decoded from a non-read cycle shows up.
  always @(posedge brq_clk) begin
    cycle     <= cycle + 1;
    mem_rdata <= mem_re ? phys_mem[mem_addr] : $urandom;
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_byte_en[b]) phys_mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic applyStimulus(input bit iv, input logic [AW-1:0] ia, input bit lv, input bit lwe,
                               input logic [AW-1:0] la, input logic [DW-1:0] lwd, input logic [3:0] lbe);
    @(posedge brq_clk);
    #1;
    if_req_valid   = iv;
    if_req_addr    = ia;
    ls_req_valid   = lv;
    ls_req_we      = lwe;
    ls_req_addr    = la;
    ls_req_wdata   = lwd;
    ls_req_byte_en = lbe;
  endtask

  // Reference model: decides who is served from the arbitration rules,
  // checks the accept-cycle memory access and queues the expected response.
  initial begin
    int  waited;
    bit  last_was_ls;
    bit  g_if, g_ls;
    waited      = 0;
    last_was_ls = 1'b0;
    forever begin
      @(negedge brq_clk);
      if (!brq_rst) begin
        waited      = 0;
        last_was_ls = 1'b0;
        sb_q.delete();
        checkOutput("rst_if_ready", 64'(if_req_ready), 64'd0);
        checkOutput("rst_ls_ready", 64'(ls_req_ready), 64'd0);
        checkOutput("rst_mem_re",   64'(mem_re), 64'd0);
        checkOutput("rst_mem_we",   64'(mem_we), 64'd0);
        checkOutput("rst_mem_addr", 64'(mem_addr), 64'd0);
      end else begin
        if (if_req_valid && ls_req_valid) begin
`ifdef BRQ_ARB_RR_EN
          g_if = last_was_ls;
`else
          g_if = (waited >= SL);
`endif
          g_ls = !g_if;
        end else begin
          g_if = if_req_valid;
          g_ls = ls_req_valid;
        end

        checkOutput("if_ready", 64'(if_req_ready), 64'(g_if));
        checkOutput("ls_ready", 64'(ls_req_ready), 64'(g_ls));
        checkOutput("mem_re", 64'(mem_re), 64'(g_if || (g_ls && !ls_req_we)));
        checkOutput("mem_we", 64'(mem_we), 64'(g_ls && ls_req_we));
        checkOutput("mem_addr", 64'(mem_addr), g_if ? 64'(if_req_addr) : g_ls ? 64'(ls_req_addr) : 64'd0);
        checkOutput("mem_wdata", 64'(mem_wdata), g_ls ? 64'(ls_req_wdata) : 64'd0);
        checkOutput("mem_byte_en", 64'(mem_byte_en), g_if ? 64'hF : g_ls ? 64'(ls_req_byte_en) : 64'd0);

        if (g_if) begin
          sb_q.push_back('{stamp: cycle + 1, is_if: 1'b1, data: ref_mem[if_req_addr]});
          last_was_ls = 1'b0;
        end
        if (g_ls) begin
          sb_q.push_back('{stamp: cycle + 1, is_if: 1'b0,
                           data: ls_req_we ? '0 : ref_mem[ls_req_addr]});
          if (ls_req_we) begin
            for (int b = 0; b < 4; b++) begin
              if (ls_req_byte_en[b]) ref_mem[ls_req_addr][8*b +: 8] = ls_req_wdata[8*b +: 8];
            end
          end
          last_was_ls = 1'b1;
        end
        waited = (if_req_valid && !g_if) ? ((waited + 1 > SL) ? SL : waited + 1) : 0;
      end
    end
  end

  // Monitor: compares what the DUT presents on the response ports against
  // the scoreboard entry due this cycle (none due means no valid allowed).
  initial begin
    exp_t e;
    bit   exp_if, exp_ls;
    forever begin
      @(negedge brq_clk);
      if (!brq_rst) begin
        checkOutput("rst_if_rsp_valid", 64'(if_rsp_valid), 64'd0);
        checkOutput("rst_ls_rsp_valid", 64'(ls_rsp_valid), 64'd0);
        checkOutput("rst_if_rsp_data",  64'(if_rsp_data), 64'd0);
        checkOutput("rst_ls_rsp_data",  64'(ls_rsp_data), 64'd0);
      end else begin
        exp_if = 1'b0;
        exp_ls = 1'b0;
        if (sb_q.size() > 0 && sb_q[0].stamp == cycle) begin
          e      = sb_q.pop_front();
          exp_if = e.is_if;
          exp_ls = !e.is_if;
        end
        checkOutput("if_rsp_valid", 64'(if_rsp_valid), 64'(exp_if));
        checkOutput("ls_rsp_valid", 64'(ls_rsp_valid), 64'(exp_ls));
        if (exp_if) checkOutput("if_rsp_data", 64'(if_rsp_data), 64'(e.data));
        if (exp_ls) checkOutput("ls_rsp_data", 64'(ls_rsp_data), 64'(e.data));
      end
    end
  end

  // Stimulus sequence.
  initial begin
    bit            exp_seq [6];
    logic [DW-1:0] v;

    for (int i = 0; i < MemWords; i++) begin
      phys_mem[i] = '0;
      ref_mem[i]  = '0;
    end
    for (int i = 0; i < 64; i++) begin
      v           = $urandom;
      phys_mem[i] = v;
      ref_mem[i]  = v;
    end
    phys_mem[16'h0010] = 32'h0000_0013;
    ref_mem[16'h0010]  = 32'h0000_0013;

`ifdef BRQ_ARB_RR_EN
    exp_seq = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_seq = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
`endif

    repeat (3) @(posedge brq_clk);
    #1 brq_rst = 1'b1;
    $display("[TB] reset released");

    // Both ports requesting straight out of reset.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, AW'(i), 1'b1, 1'b0, AW'(i + 8), '0, 4'hF);
      @(negedge brq_clk);
      #1 checkOutput("burst_if_grant", 64'(if_req_ready), 64'(exp_seq[i]));
      checkOutput("burst_ls_grant", 64'(ls_req_ready), 64'(!exp_seq[i]));
    end
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, 4'h0);

    // Fetch-only read.
    applyStimulus(1'b1, AW'(16'h0010), 1'b0, 1'b0, '0, '0, 4'h0);
    @(negedge brq_clk);
    #1 checkOutput("fetch_ready", 64'(if_req_ready), 64'd1);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, 4'h0);
    @(negedge brq_clk);
    #1 checkOutput("fetch_rsp_valid", 64'(if_rsp_valid), 64'd1);
    checkOutput("fetch_rsp_data", 64'(if_rsp_data), 64'h13);

    // Partial store.
    applyStimulus(1'b0, '0, 1'b1, 1'b1, AW'(16'h0100), 32'hDEAD_BEEF, 4'b0011);
    @(negedge brq_clk);
    #1 checkOutput("store_mem_we", 64'(mem_we), 64'd1);
    checkOutput("store_mem_addr", 64'(mem_addr), 64'h100);
    checkOutput("store_mem_wdata", 64'(mem_wdata), 64'hDEAD_BEEF);
    checkOutput("store_mem_be", 64'(mem_byte_en), 64'b0011);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, 4'h0);
    @(negedge brq_clk);
    #1 checkOutput("store_rsp_valid", 64'(ls_rsp_valid), 64'd1);
    checkOutput("store_rsp_data", 64'(ls_rsp_data), 64'd0);

    // Random traffic; load/store heavy so fetch starvation is exercised.
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, AW'($urandom_range(0, 63)),
                    $urandom_range(0, 4) != 0, $urandom_range(0, 2) == 0,
                    AW'($urandom_range(0, 63)), $urandom, 4'($urandom_range(0, 15)));
    end
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, 4'h0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, 4'h0);

    // Reset arriving while a fetch response is on the bus.
    applyStimulus(1'b1, AW'(16'h0010), 1'b0, 1'b0, '0, '0, 4'h0);
    @(negedge brq_clk);
    #1 checkOutput("pre_rst_fetch_ready", 64'(if_req_ready), 64'd1);
    @(posedge brq_clk);
    #1 if_req_valid = 1'b0;
    checkOutput("pre_rst_if_rsp_valid", 64'(if_rsp_valid), 64'd1);
    #1 brq_rst = 1'b0;
    #1 checkOutput("async_rst_if_rsp_valid", 64'(if_rsp_valid), 64'd0);
    checkOutput("async_rst_if_rsp_data", 64'(if_rsp_data), 64'd0);
    repeat (2) @(posedge brq_clk);
    #1 brq_rst = 1'b1;
    repeat (4) @(posedge brq_clk);
    @(negedge brq_clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
